// File: rtl/slot_init_scheduler_pkg.sv
// Shared widths, entry payload and FSM encoding for the slot-init scheduler.
package slot_init_scheduler_pkg;

   localparam int unsigned PRN_WIDTH          = 6;
   localparam int unsigned DOPPLER_INC_WIDTH  = 16;
   localparam int unsigned CS_WIDTH           = 11;
   localparam int unsigned SEEK_CNT_WIDTH     = 16;
   localparam int unsigned SEEK_IGNORE_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_SEEK   = 3'd2,
      ST_SELECT = 3'd3,
      ST_GRANT  = 3'd4
   } sched_state_t;

   typedef struct packed {
      logic [PRN_WIDTH-1:0]         prn;
      logic [DOPPLER_INC_WIDTH-1:0] dphi;
      logic [CS_WIDTH-1:0]          code_shift;
   } acq_entry_t;

   localparam int unsigned ENTRY_WIDTH = $bits(acq_entry_t);

endpackage

// File: rtl/slot_init_scheduler_sync_fifo.sv
// Synchronous show-ahead FIFO; a push while full is discarded, full/empty are registered.
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CNT_W-1:0] count_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)      count_nxt = count + CNT_W'(1);
      else if (!do_push && do_pop) count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/slot_init_scheduler.sv
// Queues acquisitions, runs the C/A seek for each, then hands the entry to the lowest free channel.
module slot_init_scheduler
   import slot_init_scheduler_pkg::*;
#(
   parameter  int unsigned               NUM_CHANNELS = 2,
   parameter  int unsigned               FIFO_DEPTH   = 4,
   parameter  logic [SEEK_CNT_WIDTH-1:0] SEEK_TIMEOUT = 16'd40000,
   localparam int unsigned               CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         acq_valid,
   input  logic [PRN_WIDTH-1:0]         acq_prn,
   input  logic [DOPPLER_INC_WIDTH-1:0] acq_carrier_dphi,
   input  logic [CS_WIDTH-1:0]          acq_code_shift,
   output logic                         ca_init_start,
   output logic [PRN_WIDTH-1:0]         init_prn,
   output logic [DOPPLER_INC_WIDTH-1:0] init_carrier_dphi,
   output logic [CS_WIDTH-1:0]          init_code_shift,
   input  logic                         seek_complete,
   input  logic [NUM_CHANNELS-1:0]      slot_free,
   output logic [NUM_CHANNELS-1:0]      init_ready,
   input  logic [NUM_CHANNELS-1:0]      slot_initializing,
   output logic                         busy,
   output logic [CNT_W-1:0]             pending_count,
   output logic                         acq_dropped,
   output logic                         seek_timeout
);

   sched_state_t              state;
   logic [SEEK_CNT_WIDTH-1:0] seek_cnt;
   acq_entry_t                push_entry;
   acq_entry_t                head;
   logic [ENTRY_WIDTH-1:0]    head_bits;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic [NUM_CHANNELS-1:0]   free_lowest;
   logic                      grant_ack;
   logic                      grant_still_free;

   assign push_entry = '{prn: acq_prn, dphi: acq_carrier_dphi, code_shift: acq_code_shift};
   assign head       = acq_entry_t'(head_bits);
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;

   sync_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (acq_valid),
      .pop   (fifo_pop),
      .din   (push_entry),
      .dout  (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending_count)
   );

   // Isolate the lowest set bit: x & -x.
   assign free_lowest      = slot_free & (~slot_free + NUM_CHANNELS'(1));
   assign grant_ack        = |(slot_initializing & init_ready);
   assign grant_still_free = |(slot_free & init_ready);
   assign busy             = (state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         seek_cnt          <= '0;
         ca_init_start     <= 1'b0;
         init_prn          <= '0;
         init_carrier_dphi <= '0;
         init_code_shift   <= '0;
         init_ready        <= '0;
         acq_dropped       <= 1'b0;
         seek_timeout      <= 1'b0;
      end else begin
         ca_init_start <= 1'b0;
         seek_timeout  <= 1'b0;
         acq_dropped   <= acq_valid && fifo_full;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  init_prn          <= head.prn;
                  init_carrier_dphi <= head.dphi;
                  init_code_shift   <= head.code_shift;
                  ca_init_start     <= 1'b1;
                  state             <= ST_START;
               end
            end
            ST_START: begin
               seek_cnt <= '0;
               state    <= ST_SEEK;
            end
            // The initializer may still report the previous target for a couple of cycles.
            ST_SEEK: begin
               if (seek_complete && (seek_cnt >= SEEK_CNT_WIDTH'(SEEK_IGNORE_CYCLES))) begin
                  state <= ST_SELECT;
               end else if (seek_cnt == SEEK_TIMEOUT - SEEK_CNT_WIDTH'(1)) begin
                  seek_timeout <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  seek_cnt <= seek_cnt + SEEK_CNT_WIDTH'(1);
               end
            end
            ST_SELECT: begin
               if (|slot_free) begin
                  init_ready <= free_lowest;
                  state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (grant_ack) begin
                  init_ready <= '0;
                  state      <= ST_IDLE;
               end else if (!grant_still_free) begin
                  init_ready <= '0;
                  state      <= ST_SELECT;
               end
            end
            default: begin
               init_ready <= '0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
